ahb_burst_ap: RTL and testbench
===============================

# ahb_burst_ap

Parametrised AHB access point that generalises the single-transfer AP with multi-beat bursts, configurable data/address width and correct sub-word byte strobes. It pops command and data words from the JTAG-to-AFT clock-crossing FIFO and drives the AFT-side bus master port. Read data and write status go back to the return FIFO. It sits between the async FIFO pair and the system bus in the AFT_CLK domain.

## Interface
- DATA_W, 32: bus data width; 32 or 64.
- ADDR_W, 32: bus address width.
- CNT_W, 6: burst count field width; max burst 2^CNT_W beats.
- Derived: BE_W = DATA_W/8; CMD_W = DATA_W+CNT_W+4.
- AFT_CLK  in  1  sole clock.
- TRST  in  1  reset, synchronous, active-high.
- cmd_rdata  in  CMD_W  FIFO head, first-word-fall-through; {payload[DATA_W-1:0], reg_sel, size[1:0], count[CNT_W-1:0], rw}.
- cmd_rempty  in  1  command FIFO empty.
- cmd_rinc  out  1  pop command FIFO.
- rsp_wdata  out  DATA_W+1  {err, payload} to return FIFO.
- rsp_wfull  in  1  return FIFO full.
- rsp_winc  out  1  push return FIFO.
- bus_ren, bus_wen  out  1  bus read/write request.
- bus_addr  out  ADDR_W  beat address, size-aligned.
- bus_wdata  out  DATA_W  write data.
- bus_strobe  out  BE_W  byte enables.
- bus_rdata  in  DATA_W  read data, valid when request high and bus_busy low.
- bus_busy  in  1  slave stall.
- bus_error  in  1  slave error, valid with completion.
- ap_active  out  1  high whenever state is not IDLE.
- proto_err  out  1  one-cycle pulse on malformed command stream.

## Operation
- Address word (reg_sel=1): payload[ADDR_W-1:0] is start address, beats = count+1, rw 0=read 1=write, size 0=byte 1=half 2=word 3=dword. Data word (reg_sel=0): payload is write data.
- States: IDLE, RREQ, RPUSH, WDATA, WREQ, STAT.
- IDLE, head present: pop it. Address word: latch fields, clear beat counter and sticky error, go to RREQ (read) or WDATA (write). Data word: discard it and pulse proto_err.
- Illegal size, meaning 2^size > BE_W: pop the word, pulse proto_err, go to STAT with err=1 and beats_done=0.
- RREQ: hold bus_ren until bus_busy=0, capture rdata/error, go to RPUSH. RPUSH: when rsp_wfull=0, push {error, rdata}. Then go to RREQ for the next beat or IDLE after the last beat. A bus error does not abort a read burst.
- WDATA, head present: data word is popped, latched, and the FSM goes to WREQ. Address word is not popped; the burst aborts to STAT with err=1 and the address word is processed from IDLE.
- WREQ: hold bus_wen until bus_busy=0, OR bus_error into the sticky error, then go to WDATA for the next beat or STAT after the last beat.
- STAT: when rsp_wfull=0, push {sticky_err, zero-extended beats_done}, then go to IDLE.
- Strobes: byte = 1<<addr[lsb]; half/word/dword = contiguous mask shifted to the aligned lane. Address low log2(2^size) bits are forced to 0.
- Address advance per beat: +2^size, modulo 2^ADDR_W (wraps silently).

## Timing
- Reset (TRST high at an edge): state IDLE; all outputs 0; counters and sticky error cleared. A reset mid-burst abandons the in-flight bus transfer, and ren/wen drop after that edge.
- cmd_rinc and rsp_winc are combinational from state and FIFO flags, at most one cycle each. cmd_rinc is never high when cmd_rempty is high. rsp_winc is never high when rsp_wfull is high.
- bus_addr, bus_wdata and bus_strobe are registered and stable while the request is high. The request drops the cycle after completion.
- Zero-wait read beat: 2 cycles (RREQ, RPUSH). Zero-wait write beat with data ready: 2 cycles (WDATA, WREQ).
- Simultaneous completion and TRST: reset wins; no push.

## Configuration
- AHB_AP_AUTOINC_EN defined: the address advances per beat as above.
- Undefined: every beat uses the start address (FIFO-style peripheral access). Strobes are still derived from size and the start address.

## Structure
- Package ahb_ap_pkg:
  - state_t enum
  - size_t enum (BYTE, HALF, WORD, DWORD)
  - command-field offset localparams as functions of DATA_W/CNT_W
- Sub-module ahb_ap_strobe_gen: combinational; size plus address low bits in, aligned address mask and bus_strobe out; parametrised by BE_W.

## Test plan
- Read, addr 0x1000, size 2, count 3, zero-wait slave -> reads at 0x1000/04/08/0C, strobe 0xF, four pushes {0,data}, 8 cycles from first RREQ.
- Write, addr 0x2001, size 0, count 1, data 0xAA and 0xBB -> beats at 0x2001 strobe 0x2 and 0x2002 strobe 0x4; status {0,2}.
- Write count 2 with bus_error on beat 1 and bus_busy=1 for 3 cycles per beat -> all 3 beats issued; status {1,3}; wen held 4 cycles per beat.
- Write count 3 with an address word arriving after 2 data words -> status {1,2}; the new address word is then executed.
- Data word in IDLE -> popped, proto_err pulses once, no bus activity.
- rsp_wfull=1 during a read burst -> FSM holds in RPUSH with no extra bus request. TRST asserted mid-RREQ -> next cycle all outputs 0 and state IDLE.

Source files
------------

// File: rtl/ahb_ap_pkg.sv
// ahb_ap_pkg: shared types and command-word layout for the AHB burst access point.
//   state_t  : access-point FSM states
//   size_t   : transfer size encoding (byte/half/word/dword)
//   Command word layout (LSB first): rw, count[CNT_W-1:0], size[1:0], reg_sel, payload[DATA_W-1:0]
package ahb_ap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RREQ  = 3'd1,
    ST_RPUSH = 3'd2,
    ST_WDATA = 3'd3,
    ST_WREQ  = 3'd4,
    ST_STAT  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_t;

  localparam int RW_BIT  = 0;
  localparam int CNT_LSB = 1;

  function automatic int size_lsb(input int cnt_w);
    return cnt_w + 1;
  endfunction

  function automatic int sel_bit(input int cnt_w);
    return cnt_w + 3;
  endfunction

  function automatic int pay_lsb(input int cnt_w);
    return cnt_w + 4;
  endfunction

  function automatic int cmd_width(input int data_w, input int cnt_w);
    return data_w + cnt_w + 4;
  endfunction

  // A size is usable only if its byte count fits in one bus beat.
  function automatic logic size_legal(input size_t sz, input int be_w);
    return ((32'd1 << sz) <= 32'(be_w));
  endfunction

endpackage

// File: rtl/ahb_ap_strobe_gen.sv
// ahb_ap_strobe_gen: combinational byte-lane decoder.
//   size            in  transfer size
//   addr_lo         in  address bits that select a byte lane
//   addr_lo_aligned out addr_lo with the sub-size bits forced to zero
//   strobe          out byte enables for the aligned lane group
module ahb_ap_strobe_gen
  import ahb_ap_pkg::*;
#(
  parameter  int BE_W   = 4,
  localparam int LANE_W = (BE_W > 1) ? $clog2(BE_W) : 1
) (
  input  size_t             size,
  input  logic [LANE_W-1:0] addr_lo,
  output logic [LANE_W-1:0] addr_lo_aligned,
  output logic [BE_W-1:0]   strobe
);

  logic [LANE_W-1:0] low_mask;
  logic [BE_W-1:0]   base;

  always_comb begin
    low_mask = '0;
    base     = '0;
    for (int i = 0; i < LANE_W; i++) begin
      if (i < int'(size)) low_mask[i] = 1'b1;
    end
    for (int b = 0; b < BE_W; b++) begin
      if (b < (1 << size)) base[b] = 1'b1;
    end
    addr_lo_aligned = addr_lo & ~low_mask;
    strobe          = base << addr_lo_aligned;
  end

endmodule

// File: rtl/ahb_burst_ap.sv
// ahb_burst_ap: AHB access point with multi-beat bursts, AFT_CLK domain.
// Pops address/data words from the command FIFO, drives the bus master port,
// and pushes read data or write status into the return FIFO.
//   AFT_CLK, TRST              clock, synchronous active-high reset
//   cmd_rdata/cmd_rempty/cmd_rinc  command FIFO (first-word-fall-through)
//   rsp_wdata/rsp_wfull/rsp_winc   return FIFO, {err, payload}
//   bus_ren/bus_wen/bus_addr/bus_wdata/bus_strobe  registered bus request
//   bus_rdata/bus_busy/bus_error   slave response
//   ap_active                   state is not IDLE
//   proto_err                   one-cycle pulse on a malformed command stream
// Build option: define AHB_AP_AUTOINC_EN to advance the address by the
// transfer size on every beat; otherwise every beat reuses the start address.
module ahb_burst_ap
  import ahb_ap_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 32,
  parameter  int CNT_W  = 6,
  localparam int BE_W   = DATA_W / 8,
  localparam int CMD_W  = DATA_W + CNT_W + 4
) (
  input  logic              AFT_CLK,
  input  logic              TRST,
  input  logic [CMD_W-1:0]  cmd_rdata,
  input  logic              cmd_rempty,
  output logic              cmd_rinc,
  output logic [DATA_W:0]   rsp_wdata,
  input  logic              rsp_wfull,
  output logic              rsp_winc,
  output logic              bus_ren,
  output logic              bus_wen,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [BE_W-1:0]   bus_strobe,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_busy,
  input  logic              bus_error,
  output logic              ap_active,
  output logic              proto_err
);

  localparam int LANE_W   = (BE_W > 1) ? $clog2(BE_W) : 1;
  localparam int SIZE_LSB = size_lsb(CNT_W);
  localparam int SEL_BIT  = sel_bit(CNT_W);
  localparam int PAY_LSB  = pay_lsb(CNT_W);

  // Command head field decode
  logic [DATA_W-1:0] cmd_payload;
  logic              cmd_sel;
  size_t             cmd_size;
  logic [CNT_W-1:0]  cmd_count;
  logic              cmd_rw;
  logic              cmd_legal;

  assign cmd_payload = cmd_rdata[PAY_LSB +: DATA_W];
  assign cmd_sel     = cmd_rdata[SEL_BIT];
  assign cmd_size    = size_t'(cmd_rdata[SIZE_LSB +: 2]);
  assign cmd_count   = cmd_rdata[CNT_LSB +: CNT_W];
  assign cmd_rw      = cmd_rdata[RW_BIT];
  assign cmd_legal   = size_legal(cmd_size, BE_W);

  state_t            state_q, state_d;
  size_t             size_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W:0]    beat_q;
  logic              sticky_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   strobe_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rerr_q;

  logic ld_cmd, ld_bad, ld_wdata, cap_rd, beat_done, abort, advance, last_beat;

  assign last_beat = (beat_q == {1'b0, count_q});

  // State register
  always_ff @(posedge AFT_CLK) begin
    if (TRST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!cmd_rempty && cmd_sel) begin
          if (!cmd_legal)  state_d = ST_STAT;
          else if (cmd_rw) state_d = ST_WDATA;
          else             state_d = ST_RREQ;
        end
      end
      ST_RREQ:  if (!bus_busy)   state_d = ST_RPUSH;
      ST_RPUSH: if (!rsp_wfull)  state_d = last_beat ? ST_IDLE : ST_RREQ;
      ST_WDATA: if (!cmd_rempty) state_d = cmd_sel ? ST_STAT : ST_WREQ;
      ST_WREQ:  if (!bus_busy)   state_d = last_beat ? ST_STAT : ST_WDATA;
      ST_STAT:  if (!rsp_wfull)  state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Output and datapath-enable logic
  always_comb begin
    cmd_rinc  = 1'b0;
    rsp_winc  = 1'b0;
    rsp_wdata = '0;
    bus_ren   = 1'b0;
    bus_wen   = 1'b0;
    proto_err = 1'b0;
    ld_cmd    = 1'b0;
    ld_bad    = 1'b0;
    ld_wdata  = 1'b0;
    cap_rd    = 1'b0;
    beat_done = 1'b0;
    abort     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!cmd_rempty) begin
          cmd_rinc = 1'b1;
          if (cmd_sel && cmd_legal) begin
            ld_cmd = 1'b1;
          end else begin
            proto_err = 1'b1;
            ld_bad    = cmd_sel;
          end
        end
      end
      ST_RREQ: begin
        bus_ren = 1'b1;
        cap_rd  = !bus_busy;
      end
      ST_RPUSH: begin
        rsp_wdata = {rerr_q, rdata_q};
        if (!rsp_wfull) begin
          rsp_winc  = 1'b1;
          beat_done = 1'b1;
        end
      end
      ST_WDATA: begin
        // An address word here ends the burst early; it stays in the FIFO
        // so IDLE can start it as a fresh command.
        if (!cmd_rempty) begin
          if (!cmd_sel) begin
            cmd_rinc = 1'b1;
            ld_wdata = 1'b1;
          end else begin
            abort = 1'b1;
          end
        end
      end
      ST_WREQ: begin
        bus_wen   = 1'b1;
        beat_done = !bus_busy;
      end
      ST_STAT: begin
        rsp_wdata = {sticky_q, DATA_W'(beat_q)};
        rsp_winc  = !rsp_wfull;
      end
      default: ;
    endcase
    // Reset takes priority over a coincident pop or push.
    if (TRST) begin
      cmd_rinc  = 1'b0;
      rsp_winc  = 1'b0;
      proto_err = 1'b0;
    end
  end

`ifdef AHB_AP_AUTOINC_EN
  logic [ADDR_W-1:0] step;
  assign step    = ADDR_W'(1) << size_q;
  assign advance = beat_done && !last_beat;
`else
  assign advance = 1'b0;
`endif

  // Address/strobe source for the next registered beat
  logic [ADDR_W-1:0] addr_src;
  size_t             size_src;
  logic [LANE_W-1:0] lo_aligned;
  logic [BE_W-1:0]   strobe_src;

  always_comb begin
    addr_src = addr_q;
    size_src = size_q;
    if (ld_cmd) begin
      addr_src = cmd_payload[ADDR_W-1:0];
      size_src = cmd_size;
    end
`ifdef AHB_AP_AUTOINC_EN
    else if (advance) begin
      addr_src = addr_q + step;
    end
`endif
  end

  ahb_ap_strobe_gen #(.BE_W(BE_W)) u_strobe (
    .size            (size_src),
    .addr_lo         (addr_src[LANE_W-1:0]),
    .addr_lo_aligned (lo_aligned),
    .strobe          (strobe_src)
  );

  // Burst control registers and registered bus request fields
  always_ff @(posedge AFT_CLK) begin
    if (TRST) begin
      size_q   <= SZ_BYTE;
      count_q  <= '0;
      beat_q   <= '0;
      sticky_q <= 1'b0;
      addr_q   <= '0;
      strobe_q <= '0;
      wdata_q  <= '0;
    end else begin
      if (ld_cmd) begin
        size_q   <= cmd_size;
        count_q  <= cmd_count;
        beat_q   <= '0;
        sticky_q <= 1'b0;
      end
      if (ld_bad) begin
        beat_q   <= '0;
        sticky_q <= 1'b1;
      end
      if (ld_cmd || advance) begin
        addr_q   <= {addr_src[ADDR_W-1:LANE_W], lo_aligned};
        strobe_q <= strobe_src;
      end
      if (ld_wdata) wdata_q <= cmd_payload;
      if (beat_done) beat_q <= beat_q + 1'b1;
      // Write errors accumulate; read errors travel with each beat instead.
      if (beat_done && state_q == ST_WREQ) sticky_q <= sticky_q | bus_error;
      if (abort) sticky_q <= 1'b1;
    end
  end

  // Read capture: only consumed in RPUSH, so no reset needed
  always_ff @(posedge AFT_CLK) begin
    if (cap_rd) begin
      rdata_q <= bus_rdata;
      rerr_q  <= bus_error;
    end
  end

  assign bus_addr   = addr_q;
  assign bus_strobe = strobe_q;
  assign bus_wdata  = wdata_q;
  assign ap_active  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ahb_burst_ap.sv
module tb_ahb_burst_ap;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 6;
  localparam int BE_W   = 4;
  localparam int CMD_W  = DATA_W + CNT_W + 4;

  logic              AFT_CLK = 1'b0;
  logic              TRST;
  logic [CMD_W-1:0]  cmd_rdata;
  logic              cmd_rempty;
  logic              cmd_rinc;
  logic [DATA_W:0]   rsp_wdata;
  logic              rsp_wfull;
  logic              rsp_winc;
  logic              bus_ren, bus_wen;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [BE_W-1:0]   bus_strobe;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_busy;
  logic              bus_error;
  logic              ap_active;
  logic              proto_err;

  always #5 AFT_CLK = ~AFT_CLK;

  ahb_burst_ap #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .AFT_CLK(AFT_CLK), .TRST(TRST),
    .cmd_rdata(cmd_rdata), .cmd_rempty(cmd_rempty), .cmd_rinc(cmd_rinc),
    .rsp_wdata(rsp_wdata), .rsp_wfull(rsp_wfull), .rsp_winc(rsp_winc),
    .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_strobe(bus_strobe), .bus_rdata(bus_rdata),
    .bus_busy(bus_busy), .bus_error(bus_error),
    .ap_active(ap_active), .proto_err(proto_err)
  );

  typedef logic [68:0] beat_t;   // {is_write, addr, strobe, wdata}
  typedef logic [32:0] rsp_t;    // {err, payload}

  // Command FIFO model: initial writes cmd_wr, monitor advances cmd_rd
  logic [CMD_W-1:0] cmd_mem [0:511];
  int cmd_wr = 0;
  int cmd_rd = 0;
  assign cmd_rdata  = cmd_mem[cmd_rd];
  assign cmd_rempty = (cmd_rd == cmd_wr);

  // Slave model
  int          busy_len = 0;
  int          wait_cnt = 0;
  int          beat_no  = 0;
  int          err_base = 0;
  logic [63:0] err_mask = '0;
  logic [31:0] salt;
  always_comb bus_busy  = (bus_ren || bus_wen) && (wait_cnt < busy_len);
  always_comb bus_error = err_mask[6'(beat_no - err_base)];
  always_comb bus_rdata = bus_addr ^ salt;

  beat_t beat_log [$];
  rsp_t  rsp_log  [$];
  beat_t exp_beats[$];
  rsp_t  exp_rsp  [$];
  int act_cnt = 0, wen_cnt = 0, ren_cnt = 0, proto_cnt = 0, viol = 0;

  always @(posedge AFT_CLK) begin
    if (cmd_rinc) cmd_rd <= cmd_rd + 1;
    viol <= viol + ((cmd_rinc && cmd_rempty) ? 1 : 0) + ((rsp_winc && rsp_wfull) ? 1 : 0);
    if (rsp_winc) rsp_log.push_back(rsp_wdata);
    if (ap_active) act_cnt <= act_cnt + 1;
    if (bus_wen)   wen_cnt <= wen_cnt + 1;
    if (bus_ren)   ren_cnt <= ren_cnt + 1;
    if (proto_err) proto_cnt <= proto_cnt + 1;
    if (TRST) begin
      wait_cnt <= 0;
    end else if (bus_ren || bus_wen) begin
      if (bus_busy) begin
        wait_cnt <= wait_cnt + 1;
      end else begin
        wait_cnt <= 0;
        beat_no  <= beat_no + 1;
        beat_log.push_back({bus_wen, bus_addr, bus_strobe, bus_wen ? bus_wdata : 32'h0});
      end
    end
  end

  int n_checks = 0;
  int n_err    = 0;
  int bchk     = 0;
  int rchk     = 0;
  logic [31:0] wd_buf [0:63];

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CMD_W-1:0] aw(input logic [31:0] a, input int sz, input int cnt, input bit rw);
    return {a, 1'b1, 2'(sz), 6'(cnt), rw};
  endfunction

  function automatic logic [CMD_W-1:0] dw(input logic [31:0] d);
    return {d, 1'b0, 2'b00, 6'd0, 1'b0};
  endfunction

  task automatic push_cmd(input logic [CMD_W-1:0] w);
    cmd_mem[cmd_wr] = w;
    cmd_wr++;
  endtask

  // Reference: what a burst of `issued` beats should look like on the bus and
  // in the return FIFO, from start address, size and the error pattern.
  task automatic model_burst(input logic [31:0] start, input int sz, input int issued,
                             input bit wr, input bit abort_flag);
    logic [31:0] a0, ai;
    logic [3:0]  st;
    bit          sticky;
    sticky = abort_flag;
    a0 = start & ~((32'd1 << sz) - 32'd1);
    for (int i = 0; i < issued; i++) begin
`ifdef AHB_AP_AUTOINC_EN
      ai = a0 + 32'(i * (1 << sz));
`else
      ai = a0;
`endif
      st = 4'(((1 << (1 << sz)) - 1) << ai[1:0]);
      exp_beats.push_back({wr, ai, st, wr ? wd_buf[i] : 32'h0});
      if (wr) sticky = sticky | err_mask[i];
      else    exp_rsp.push_back({err_mask[i], ai ^ salt});
    end
    if (wr) exp_rsp.push_back({sticky, 32'(issued)});
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge AFT_CLK);
      n++;
    end while ((ap_active || cmd_rd != cmd_wr) && n < 400);
    check({tag, "_idle"}, {ap_active, cmd_rd != cmd_wr}, 2'b00);
  endtask

  task automatic compare_logs(input string tag);
    check({tag, "_nbeats"}, beat_log.size(), exp_beats.size());
    check({tag, "_nrsp"}, rsp_log.size(), exp_rsp.size());
    for (int i = bchk; i < exp_beats.size() && i < beat_log.size(); i++)
      check({tag, "_beat"}, beat_log[i], exp_beats[i]);
    for (int i = rchk; i < exp_rsp.size() && i < rsp_log.size(); i++)
      check({tag, "_rsp"}, rsp_log[i], exp_rsp[i]);
    bchk = exp_beats.size();
    rchk = exp_rsp.size();
  endtask

  task automatic start_test(input int blen, input logic [63:0] emask);
    busy_len = blen;
    err_mask = emask;
    err_base = beat_no;
  endtask

  initial begin
    int a0, w0, r0, p0, n, sz, cnt;
    bit rw;
    logic [31:0] addr;
    for (int i = 0; i < 512; i++) cmd_mem[i] = '0;
    salt      = $urandom;
    TRST      = 1'b1;
    rsp_wfull = 1'b0;

    // Reset state
    repeat (3) @(posedge AFT_CLK);
    #1;
    check("reset_outs", {bus_ren, bus_wen, bus_addr, bus_wdata, bus_strobe, cmd_rinc,
                         rsp_winc, rsp_wdata, ap_active, proto_err}, '0);
    @(negedge AFT_CLK);
    TRST = 1'b0;

    // Read burst, zero-wait: 4 beats in 8 cycles
    start_test(0, '0);
    a0 = act_cnt;
    push_cmd(aw(32'h1000, 2, 3, 1'b0));
    model_burst(32'h1000, 2, 4, 1'b0, 1'b0);
    wait_idle("rd4");
    check("rd4_cycles", 32'(act_cnt - a0), 32'd8);
    compare_logs("rd4");

    // Byte write burst from an odd address
    start_test(0, '0);
    a0 = act_cnt;
    wd_buf[0] = 32'hAA; wd_buf[1] = 32'hBB;
    push_cmd(aw(32'h2001, 0, 1, 1'b1));
    push_cmd(dw(32'hAA));
    push_cmd(dw(32'hBB));
    model_burst(32'h2001, 0, 2, 1'b1, 1'b0);
    wait_idle("wrb");
    check("wrb_cycles", 32'(act_cnt - a0), 32'd5);
    compare_logs("wrb");

    // Write with stalls and an error on beat 1
    start_test(3, 64'h2);
    w0 = wen_cnt;
    for (int i = 0; i < 3; i++) wd_buf[i] = $urandom;
    push_cmd(aw(32'h4000, 2, 2, 1'b1));
    for (int i = 0; i < 3; i++) push_cmd(dw(wd_buf[i]));
    model_burst(32'h4000, 2, 3, 1'b1, 1'b0);
    wait_idle("wrerr");
    check("wrerr_wen_cycles", 32'(wen_cnt - w0), 32'd12);
    compare_logs("wrerr");

    // Write cut short by an address word, which then runs as a read
    start_test(0, '0);
    wd_buf[0] = 32'h1111_0000; wd_buf[1] = 32'h2222_0000;
    push_cmd(aw(32'h5000, 2, 3, 1'b1));
    push_cmd(dw(wd_buf[0]));
    push_cmd(dw(wd_buf[1]));
    push_cmd(aw(32'h6000, 2, 0, 1'b0));
    model_burst(32'h5000, 2, 2, 1'b1, 1'b1);
    start_test(0, '0);
    model_burst(32'h6000, 2, 1, 1'b0, 1'b0);
    start_test(0, '0);
    wait_idle("abort");
    compare_logs("abort");

    // Stray data word in IDLE
    p0 = proto_cnt;
    push_cmd(dw(32'h1234));
    wait_idle("stray");
    check("stray_proto", 32'(proto_cnt - p0), 32'd1);
    compare_logs("stray");

    // Illegal size (dword on a 32-bit bus)
    p0 = proto_cnt;
    push_cmd(aw(32'h7000, 3, 0, 1'b0));
    exp_rsp.push_back({1'b1, 32'h0});
    wait_idle("illegal");
    check("illegal_proto", 32'(proto_cnt - p0), 32'd1);
    compare_logs("illegal");

    // Return FIFO full during a read: hold in RPUSH without re-requesting
    start_test(0, 64'h1);
    rsp_wfull = 1'b1;
    r0 = ren_cnt;
    push_cmd(aw(32'h3000, 2, 1, 1'b0));
    repeat (10) @(negedge AFT_CLK);
    check("full_ren_cycles", 32'(ren_cnt - r0), 32'd1);
    check("full_held", {ap_active, 32'(rsp_log.size())}, {1'b1, 32'(rchk)});
    rsp_wfull = 1'b0;
    model_burst(32'h3000, 2, 2, 1'b0, 1'b0);
    wait_idle("full");
    compare_logs("full");

    // Randomised bursts, including one that crosses the top of the address space
    for (int t = 0; t < 8; t++) begin
      sz   = $urandom_range(0, 2);
      cnt  = $urandom_range(0, 4);
      rw   = 1'($urandom_range(0, 1));
      addr = (t == 3) ? 32'hFFFF_FFF8 : $urandom;
      start_test($urandom_range(0, 2), {$urandom, $urandom});
      push_cmd(aw(addr, sz, cnt, rw));
      if (rw) begin
        for (int i = 0; i <= cnt; i++) begin
          wd_buf[i] = $urandom;
          push_cmd(dw(wd_buf[i]));
        end
      end
      model_burst(addr, sz, cnt + 1, rw, 1'b0);
      wait_idle("rand");
      compare_logs("rand");
    end

    // Reset in the middle of a stalled read request
    start_test(5, '0);
    push_cmd(aw(32'h8000, 2, 2, 1'b0));
    n = 0;
    do begin
      @(negedge AFT_CLK);
      n++;
    end while (!bus_ren && n < 20);
    check("rst_ren_seen", bus_ren, 1'b1);
    TRST = 1'b1;
    @(posedge AFT_CLK);
    #1;
    check("rst_mid_outs", {bus_ren, bus_wen, bus_addr, bus_wdata, bus_strobe, cmd_rinc,
                           rsp_winc, rsp_wdata, ap_active, proto_err}, '0);
    @(negedge AFT_CLK);
    TRST = 1'b0;
    start_test(0, '0);
    repeat (4) @(negedge AFT_CLK);
    check("rst_stays_idle", {ap_active, bus_ren}, 2'b00);
    compare_logs("rst");

    check("fifo_flag_rules", 32'(viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
